// File: rtl/radix4_booth_mult.sv
// ---------------------------------------------------------------------------
// radix4_booth_mult
//   Sequential signed multiplier using radix-4 (modified Booth) recoding.
//   One Booth digit is retired per clock, so a WIDTH-bit operand pair takes
//   NDIG = WIDTH/2 digit cycles plus one cycle to publish the product.
//   Valid/ready on both sides, one transaction in flight, and the product is
//   held on C until the consumer takes it.
//
//   Optional build macro: RADIX4_MULT_ZERO_SKIP_EN
//     When defined, an operand pair with a zero operand skips the digit loop
//     and finishes with C = 0 one cycle after the input handshake.
// ---------------------------------------------------------------------------
module radix4_booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 vld_in,
    output logic                 rdy_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   C,
    output logic                 vld_out,
    input  logic                 rdy_out
);

    // Digit count and datapath widths. The accumulator carries two guard
    // bits so that adding +/-2*mcand can never wrap.
    localparam int NDIG = WIDTH / 2;
    localparam int AW   = WIDTH + 2;              // accumulator / multiplicand
    localparam int PW   = AW + WIDTH + 1;         // {acc, multiplier, booth bit}
    localparam int CW   = $clog2(NDIG + 1);       // counts 0..NDIG

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       mcand_q;
    logic [PW-1:0]       p_q;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  c_q;
    logic                rdy_in_q;
    logic                vld_out_q;

    logic [2:0]          trip;
    logic [AW-1:0]       pp;
    logic [AW-1:0]       acc_sum;
    logic [PW-1:0]       p_d;

    assign rdy_in  = rdy_in_q;
    assign vld_out = vld_out_q;
    assign C       = c_q;

    // Booth digit recode of the current triplet and one accumulate-and-shift step.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path can leave it unassigned and infer a latch.
        trip    = p_q[2:0];
        pp      = '0;
        case (trip)
            3'b001, 3'b010: pp = mcand_q;            // +1
            3'b011:         pp = mcand_q << 1;       // +2
            3'b100:         pp = -(mcand_q << 1);    // -2
            3'b101, 3'b110: pp = -mcand_q;           // -1
            default:        pp = '0;                 // 000 / 111 -> 0
        endcase
        acc_sum = p_q[PW-1:WIDTH+1] + pp;
        // Arithmetic shift right by two: replicate the accumulator sign bit.
        p_d     = {{2{acc_sum[AW-1]}}, acc_sum, p_q[WIDTH:2]};
    end

`ifdef RADIX4_MULT_ZERO_SKIP_EN
    logic zero_op;
    // Captured multiplicand or multiplier is zero: the product is known to be 0.
    always_comb begin
        zero_op = (mcand_q == '0) || (p_q[WIDTH:1] == '0);
    end
`endif

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge CLK) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            c_q       <= '0;
            rdy_in_q  <= 1'b1;
            vld_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (vld_in && rdy_in_q) begin
                        mcand_q  <= {{2{A[WIDTH-1]}}, A};
                        p_q      <= {{AW{1'b0}}, B, 1'b0};
                        cnt_q    <= '0;
                        rdy_in_q <= 1'b0;
                        state_q  <= S_BUSY;
                    end
                end

                S_BUSY: begin
`ifdef RADIX4_MULT_ZERO_SKIP_EN
                    if ((cnt_q == '0) && zero_op) begin
                        c_q       <= '0;
                        vld_out_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else
`endif
                    if (cnt_q == CW'(NDIG)) begin
                        // All digits retired: the exact product sits just
                        // above the Booth guard bit.
                        c_q       <= p_q[2*WIDTH:1];
                        vld_out_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        p_q   <= p_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DONE: begin
                    // Product stays on C until the consumer accepts it.
                    if (vld_out_q && rdy_out) begin
                        vld_out_q <= 1'b0;
                        rdy_in_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    rdy_in_q  <= 1'b1;
                    vld_out_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_booth_mult.sv
// ---------------------------------------------------------------------------
// tb_radix4_booth_mult
//   Scoreboard bench: each accepted operand pair pushes its reference product
//   and expected latency; results are popped and compared as they appear.
// ---------------------------------------------------------------------------
module tb_radix4_booth_mult;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 1;
`ifdef RADIX4_MULT_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = LAT;
`endif
    localparam int TMO = 100;

    logic           CLK = 1'b0;
    logic           rst;
    logic           vld_in;
    logic           rdy_in;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] C;
    logic           vld_out;
    logic           rdy_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];

    radix4_booth_mult #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .rst     (rst),
        .vld_in  (vld_in),
        .rdy_in  (rdy_in),
        .A       (A),
        .B       (B),
        .C       (C),
        .vld_out (vld_out),
        .rdy_out (rdy_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Present one operand pair, wait for the handshake, record the expectation.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        logic signed [2*W-1:0] prod;
        guard = 0;
        while (rdy_in !== 1'b1 && guard < TMO) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= TMO) begin
            n_err++;
            $display("FAIL send_rdy_in_timeout got=%b want=1", rdy_in);
        end
        vld_in = 1'b1;
        A = a;
        B = b;
        tick();
        vld_in = 1'b0;
        A = $urandom;
        B = $urandom;
        prod = $signed(a) * $signed(b);
        exp_q.push_back(prod);
        lat_q.push_back((a == '0 || b == '0) ? ZLAT : LAT);
    endtask

    // Wait (bounded) for vld_out and pop the matching expectation.
    task automatic collect(output logic [2*W-1:0] got, output logic [2*W-1:0] exp,
                           output int lat, output int exp_lat, output logic rdy_hi);
        lat = 0;
        rdy_hi = 1'b0;
        while (vld_out !== 1'b1 && lat < TMO) begin
            if (rdy_in !== 1'b0) rdy_hi = 1'b1;
            tick();
            lat++;
        end
        if (rdy_in !== 1'b0) rdy_hi = 1'b1;
        got = C;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
        end else begin
            exp = 'x;
            exp_lat = -1;
        end
    endtask

    task automatic consume;
        rdy_out = 1'b1;
        tick();
        rdy_out = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vld_in = 1'b0;
        rdy_out = 1'b0;
        A = '0;
        B = '0;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (rdy_in !== 1'b1) begin n_err++; $display("FAIL reset_rdy_in got=%b want=1", rdy_in); end
        n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL reset_vld_out got=%b want=0", vld_out); end
        n_cmp++; if (C !== '0) begin n_err++; $display("FAIL reset_C got=%h want=0", C); end
    endtask

    task automatic test_basic;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        send(32'd100, 32'd100);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== 64'd10000 || got !== exp) begin n_err++; $display("FAIL basic_100x100 got=%0d want=%0d", got, exp); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL basic_latency got=%0d want=%0d", lat, elat); end
        consume();
        n_cmp++; if (vld_out !== 1'b0 || rdy_in !== 1'b1) begin n_err++; $display("FAIL basic_release vld_out=%b rdy_in=%b want 0/1", vld_out, rdy_in); end
        n_cmp++; if (C !== 64'd10000) begin n_err++; $display("FAIL basic_C_retained got=%0d want=10000", C); end

        send(32'd3423, 32'd1123);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== 64'd3844029 || got !== exp) begin n_err++; $display("FAIL basic_3423x1123 got=%0d want=%0d", got, exp); end
        n_cmp++; if (rdy_hi !== 1'b0) begin n_err++; $display("FAIL basic_rdy_in_busy got=%b want=0", rdy_hi); end
        consume();
    endtask

    task automatic test_signed;
        logic [W-1:0] ta [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [W-1:0] tb [5] = '{32'd5,        32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i]);
            collect(got, exp, lat, elat, rdy_hi);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL signed_%0d got=%h want=%h", i, got, exp); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL signed_lat_%0d got=%0d want=%0d", i, lat, elat); end
            consume();
        end
        n_cmp++; if (C !== 64'h0000_0000_0000_0001 * 64'h3FFF_FFFF_0000_0001) begin n_err++; $display("FAIL signed_max_retained got=%h want=3fffffff00000001", C); end
    endtask

    task automatic test_backpressure;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        send(-32'sd123456, 32'd987654);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL bp_product got=%h want=%h", got, exp); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (vld_out !== 1'b1 || C !== exp) begin n_err++; $display("FAIL bp_hold_%0d vld_out=%b C=%h want 1/%h", i, vld_out, C, exp); end
        end
        consume();
        n_cmp++; if (vld_out !== 1'b0 || rdy_in !== 1'b1) begin n_err++; $display("FAIL bp_release vld_out=%b rdy_in=%b want 0/1", vld_out, rdy_in); end
    endtask

    task automatic test_ignored_inputs;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        send(32'h0000_1234, -32'sd85);
        vld_in = 1'b1;
        rdy_out = 1'b1;
        collect(got, exp, lat, elat, rdy_hi);
        vld_in = 1'b0;
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ign_product got=%h want=%h", got, exp); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL ign_latency got=%0d want=%0d", lat, elat); end
        tick();
        rdy_out = 1'b0;
        n_cmp++; if (vld_out !== 1'b0 || rdy_in !== 1'b1) begin n_err++; $display("FAIL ign_release vld_out=%b rdy_in=%b want 0/1", vld_out, rdy_in); end
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        send(32'd555, 32'd777);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        n_cmp++; if (rdy_in !== 1'b1 || vld_out !== 1'b0) begin n_err++; $display("FAIL rstmid_flags rdy_in=%b vld_out=%b want 1/0", rdy_in, vld_out); end
        n_cmp++; if (C !== '0) begin n_err++; $display("FAIL rstmid_C got=%h want=0", C); end
        send(-32'sd9999, 32'd31337);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_next got=%h want=%h", got, exp); end
        consume();
    endtask

    task automatic test_zero;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        send(32'd0, 32'd12345);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== '0) begin n_err++; $display("FAIL zero_a got=%h want=0", got); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL zero_a_latency got=%0d want=%0d", lat, elat); end
        consume();
        send(-32'sd5, 32'd0);
        collect(got, exp, lat, elat, rdy_hi);
        n_cmp++; if (got !== '0) begin n_err++; $display("FAIL zero_b got=%h want=0", got); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL zero_b_latency got=%0d want=%0d", lat, elat); end
        consume();
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] got, exp;
        int lat, elat;
        logic rdy_hi;
        rdy_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom);
            collect(got, exp, lat, elat, rdy_hi);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_%0d got=%h want=%h", i, got, exp); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL b2b_lat_%0d got=%0d want=%0d", i, lat, elat); end
        end
        tick();
        rdy_out = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_queue_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
